alu_issue_stage: RTL and testbench

// - Decode/issue stage that produces ALU_FUN and the A/B operands the 32-bit ALU consumes.
// - Takes RV32I instructions plus register-file read data over a valid/ready handshake.
// - Decodes the ALU op and forms the operands.
// - Delivers them to the execute side through a 2-entry skid buffer, so IN_READY is a registered signal.

---
 rtl/alu_issue_stage.sv | 186 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for a 32-bit ALU: decodes RV32I ALU-class instructions into
// ALU_FUN plus A/B operands and hands them to execute through a two-entry skid buffer.
module alu_issue_stage #(
    parameter int M = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         FLUSH,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [31:0]  INSTR,
    input  logic [M-1:0] PC,
    input  logic [M-1:0] RS1_DATA,
    input  logic [M-1:0] RS2_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [M-1:0] ALU_A,
    output logic [M-1:0] ALU_B,
    output logic [3:0]   ALU_FUN,
    output logic [4:0]   RD_ADDR,
    output logic         RD_WE,
    output logic         ILLEGAL
);
    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_PASS = 4'b1001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    typedef struct packed {
        logic signed [M-1:0] a;
        logic signed [M-1:0] b;
        logic [3:0]          fun;
        logic [4:0]          rd;
        logic                we;
        logic                ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // funct3 maps straight onto the low three FUN bits; bit 3 marks SUB/SRA.
    function automatic entry_t decode(input logic [31:0]  instr,
                                      input logic [M-1:0] pc,
                                      input logic [M-1:0] rs1,
                                      input logic [M-1:0] rs2);
        entry_t              e;
        logic [2:0]          f3;
        logic signed [11:0]  i_imm;
        logic signed [31:0]  u_imm;
        f3    = instr[14:12];
        i_imm = $signed(instr[31:20]);
        u_imm = $signed({instr[31:12], 12'b0});
        e     = '0;
        e.rd  = instr[11:7];
        case (instr[6:0])
            OPC_OP: begin
                e.a   = $signed(rs1);
                e.b   = $signed(rs2);
                e.fun = {instr[30] && (f3 == 3'b000 || f3 == 3'b101), f3};
            end
            OPC_OPIMM: begin
                e.a   = $signed(rs1);
                e.fun = {instr[30] && (f3 == 3'b101), f3};
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    e.b = $signed(M'(instr[24:20]));
                end else begin
                    e.b = M'(i_imm);
                end
            end
            OPC_LUI: begin
                e.a   = M'(u_imm);
                e.fun = FUN_PASS;
            end
            OPC_AUIPC: begin
                e.a   = $signed(pc);
                e.b   = M'(u_imm);
                e.fun = FUN_ADD;
            end
            OPC_JAL, OPC_JALR: begin
                e.a   = $signed(pc);
                e.b   = M'(4);
                e.fun = FUN_ADD;
            end
            default: e.ill = 1'b1;
        endcase
        e.we = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    entry_t dec_p0;
    entry_t head_p1;
    entry_t skid_p1;
    state_t state_p1;
    state_t state_nx;
    logic   vld_p1;
    logic   rdy_p1;
    logic   push;
    logic   pop;
    logic   ld_head_new;
    logic   ld_head_skid;
    logic   ld_skid;

    assign dec_p0 = decode(INSTR, PC, RS1_DATA, RS2_DATA);
    assign push   = IN_VALID && rdy_p1;
    assign pop    = vld_p1 && OUT_READY;

    always_comb begin
        state_nx     = state_p1;
        ld_head_new  = 1'b0;
        ld_head_skid = 1'b0;
        ld_skid      = 1'b0;
        if (FLUSH) begin
            state_nx = EMPTY;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (push) begin
                        state_nx    = ONE;
                        ld_head_new = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        ld_head_new = 1'b1;
                    end else if (push) begin
                        state_nx = TWO;
                        ld_skid  = 1'b1;
                    end else if (pop) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nx     = ONE;
                        ld_head_skid = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // ---- p1: buffer state and registered handshake outputs ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
        end else begin
            state_p1 <= state_nx;
            vld_p1   <= (state_nx != EMPTY);
            rdy_p1   <= (state_nx != TWO);
        end
    end

    // Payload is cleared by reset too, so the execute side sees a clean zero entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (ld_head_new) begin
                head_p1 <= dec_p0;
            end else if (ld_head_skid) begin
                head_p1 <= skid_p1;
            end
            if (ld_skid) begin
                skid_p1 <= dec_p0;
            end
        end
    end

    assign IN_READY  = rdy_p1;
    assign OUT_VALID = vld_p1;
    assign ALU_A     = head_p1.a;
    assign ALU_B     = head_p1.b;
    assign ALU_FUN   = head_p1.fun;
    assign RD_ADDR   = head_p1.rd;
    assign RD_WE     = head_p1.we;
    assign ILLEGAL   = head_p1.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a queue-based model of the two-entry buffer plus an
// instruction-level decode model, checked every cycle, with directed literal checks.
module tb_alu_issue_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTR;
    logic [31:0] PC;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_FUN;
    logic [4:0]  RD_ADDR;
    logic        RD_WE;
    logic        ILLEGAL;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fun;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_issue_stage #(.M(32)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .PC(PC), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .RD_ADDR(RD_ADDR), .RD_WE(RD_WE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    return (alt && is_reg) ? 4'd8 : 4'd0;
            3'd1:    return 4'd1;
            3'd2:    return 4'd2;
            3'd3:    return 4'd3;
            3'd4:    return 4'd4;
            3'd5:    return alt ? 4'd13 : 4'd5;
            3'd6:    return 4'd6;
            default: return 4'd7;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        m;
        logic [2:0]  f3;
        logic [31:0] i_imm;
        f3    = ins[14:12];
        i_imm = 32'($signed(ins) >>> 20);
        m     = '0;
        m.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin m.a = r1; m.b = r2; m.fun = alu_code(f3, ins[30], 1'b1); end
            7'h13: begin
                m.a   = r1;
                m.fun = alu_code(f3, ins[30], 1'b0);
                m.b   = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : i_imm;
            end
            7'h37: begin m.a = ins & 32'hFFFFF000; m.fun = 4'd9; end
            7'h17: begin m.a = pc; m.b = ins & 32'hFFFFF000; end
            7'h6F, 7'h67: begin m.a = pc; m.b = 32'd4; end
            default: m.ill = 1'b1;
        endcase
        m.we = !m.ill && (m.rd != 5'd0);
        return m;
    endfunction

    // Model update: buffer of at most two entries, oldest at the front.
    always @(posedge RST) q.delete();

    always @(posedge CLK) begin
        bit do_push;
        bit do_pop;
        if (RST) begin
            q.delete();
        end else if (FLUSH) begin
            q.delete();
        end else begin
            do_push = IN_VALID && (q.size() < 2);
            do_pop  = (q.size() > 0) && OUT_READY;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model(INSTR, PC, RS1_DATA, RS2_DATA));
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            chk("out_valid", 32'(OUT_VALID), 32'(q.size() != 0));
            chk("in_ready", 32'(IN_READY), 32'(q.size() < 2));
            if (q.size() != 0) begin
                chk("alu_a", ALU_A, q[0].a);
                chk("alu_b", ALU_B, q[0].b);
                chk("alu_fun", 32'(ALU_FUN), 32'(q[0].fun));
                chk("rd_addr", 32'(RD_ADDR), 32'(q[0].rd));
                chk("rd_we", 32'(RD_WE), 32'(q[0].we));
                chk("illegal", 32'(ILLEGAL), 32'(q[0].ill));
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
        INSTR    = ins;
        PC       = pc;
        RS1_DATA = r1;
        RS2_DATA = r2;
        IN_VALID = 1'b1;
    endtask

    initial begin
        exp_t mdl;
        RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        INSTR = '0; PC = '0; RS1_DATA = '0; RS2_DATA = '0;

        // Model pinned against hand-decoded instructions.
        mdl = model(32'h40208033, 32'h0, 32'd7, 32'd3);
        chk("model_sub_fun", 32'(mdl.fun), 32'd8);
        mdl = model(32'h40435293, 32'h0, 32'h80000000, 32'h0);
        chk("model_srai_b", mdl.b, 32'd4);
        mdl = model(32'hFFF00393, 32'h0, 32'h0, 32'h0);
        chk("model_addi_neg_b", mdl.b, 32'hFFFFFFFF);

        repeat (2) tick();
        RST = 1'b0;
        tick();
        chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
        chk("reset_in_ready", 32'(IN_READY), 32'd1);

        // sub x0,x1,x2
        OUT_READY = 1'b1;
        put(32'h40208033, 32'h100, 32'd7, 32'd3);
        tick();
        IN_VALID = 1'b0;
        chk("sub_valid", 32'(OUT_VALID), 32'd1);
        chk("sub_fun", 32'(ALU_FUN), 32'd8);
        chk("sub_a", ALU_A, 32'd7);
        chk("sub_b", ALU_B, 32'd3);
        chk("sub_we_x0", 32'(RD_WE), 32'd0);
        tick();

        // srai x5,x6,4
        put(32'h40435293, 32'h104, 32'h80000000, 32'h0);
        tick();
        chk("srai_fun", 32'(ALU_FUN), 32'd13);
        chk("srai_b", ALU_B, 32'd4);
        chk("srai_rd", 32'(RD_ADDR), 32'd5);
        chk("srai_a", ALU_A, 32'h80000000);

        // lui x1,0xABCDE
        put(32'hABCDE0B7, 32'h108, 32'h5, 32'h6);
        tick();
        chk("lui_fun", 32'(ALU_FUN), 32'd9);
        chk("lui_a", ALU_A, 32'hABCDE000);
        chk("lui_b", ALU_B, 32'd0);

        // lw x3,0(x2): not handled here
        put(32'h00012183, 32'h10C, 32'h11, 32'h22);
        tick();
        chk("ill_flag", 32'(ILLEGAL), 32'd1);
        chk("ill_we", 32'(RD_WE), 32'd0);
        chk("ill_fun", 32'(ALU_FUN), 32'd0);
        chk("ill_a", ALU_A, 32'd0);

        // auipc, jal, addi negative
        put(32'h12345217, 32'h1000, 32'h0, 32'h0);
        tick();
        chk("auipc_b", ALU_B, 32'h12345000);
        put(32'h008000EF, 32'h2000, 32'h0, 32'h0);
        tick();
        chk("jal_a", ALU_A, 32'h2000);
        chk("jal_b", ALU_B, 32'd4);
        put(32'hFFF00393, 32'h2004, 32'h9, 32'h0);
        tick();
        IN_VALID = 1'b0;
        tick();

        // Backpressure: I0, I1 accepted, I2 waits; FIFO order after release.
        OUT_READY = 1'b0;
        put(32'h00100093, 32'h3000, 32'h0, 32'h0);
        tick();
        chk("bp_i0_ready", 32'(IN_READY), 32'd1);
        put(32'h00200113, 32'h3004, 32'h0, 32'h0);
        tick();
        chk("bp_full_ready", 32'(IN_READY), 32'd0);
        chk("bp_i0_held", ALU_B, 32'd1);
        put(32'h00300193, 32'h3008, 32'h0, 32'h0);
        tick();
        chk("bp_still_full", 32'(IN_READY), 32'd0);
        chk("bp_i0_stable", ALU_B, 32'd1);
        OUT_READY = 1'b1;
        tick();
        chk("bp_i1_next", ALU_B, 32'd2);
        chk("bp_ready_back", 32'(IN_READY), 32'd1);
        tick();
        chk("bp_i2_last", ALU_B, 32'd3);
        IN_VALID = 1'b0;
        tick();
        chk("bp_drained", 32'(OUT_VALID), 32'd0);

        // Streaming: push and pop every cycle.
        for (int i = 0; i < 10; i++) begin
            put(((32'(i) + 32'd10) << 20) | ((32'(i) + 32'd1) << 7) | 32'h13, 32'h4000, 32'h0, 32'h0);
            tick();
            chk("stream_valid", 32'(OUT_VALID), 32'd1);
            chk("stream_ready", 32'(IN_READY), 32'd1);
            chk("stream_b", ALU_B, 32'(i) + 32'd10);
        end
        IN_VALID = 1'b0;
        tick();

        // Flush with two entries held and a new instruction offered.
        OUT_READY = 1'b0;
        put(32'h00500093, 32'h5000, 32'h0, 32'h0);
        tick();
        put(32'h00600113, 32'h5004, 32'h0, 32'h0);
        tick();
        put(32'h00700193, 32'h5008, 32'h0, 32'h0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush2_valid", 32'(OUT_VALID), 32'd0);
        chk("flush2_ready", 32'(IN_READY), 32'd1);
        // Flush with one entry and a push that would otherwise be accepted.
        put(32'h00500093, 32'h5100, 32'h0, 32'h0);
        tick();
        put(32'h00700193, 32'h5104, 32'h0, 32'h0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        chk("flush1_valid", 32'(OUT_VALID), 32'd0);
        tick();
        chk("flush1_no_capture", 32'(OUT_VALID), 32'd0);

        // Asynchronous reset mid-cycle with two entries held.
        put(32'h12345217, 32'h6000, 32'h0, 32'h0);
        tick();
        put(32'h008000EF, 32'h6004, 32'h0, 32'h0);
        tick();
        IN_VALID = 1'b0;
        chk("pre_reset_full", 32'(IN_READY), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("arst_in_ready", 32'(IN_READY), 32'd1);
        chk("arst_a", ALU_A, 32'd0);
        chk("arst_b", ALU_B, 32'd0);
        chk("arst_fun", 32'(ALU_FUN), 32'd0);
        chk("arst_rd", 32'(RD_ADDR), 32'd0);
        chk("arst_we", 32'(RD_WE), 32'd0);
        chk("arst_ill", 32'(ILLEGAL), 32'd0);
        tick();
        RST = 1'b0;
        OUT_READY = 1'b1;
        tick();
        chk("post_reset_empty", 32'(OUT_VALID), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
